// File: rtl/ir_queue_if.sv
// Fetch/decode side of the instruction-register queue: load and flush strobes
// in, the head word and occupancy status out.
interface ir_queue_if #(
    parameter int INS_W = 16,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             il_in;
    logic [INS_W-1:0] ins_in;
    logic             flush_in;
    logic             take_in;
    logic [INS_W-1:0] ins_out;
    logic             ins_valid;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             ovf_err;

    modport master (
        output il_in, ins_in, flush_in, take_in,
        input  ins_out, ins_valid, full, count, ovf_err
    );

    modport slave (
        input  il_in, ins_in, flush_in, take_in,
        output ins_out, ins_valid, full, count, ovf_err
    );
endinterface

// File: rtl/ir_queue.sv
// Circular instruction-register queue between fetch and decode with a
// one-cycle flush for redirects and a sticky flag for dropped loads.
module ir_queue #(
    parameter int INS_W = 16,
    parameter int DEPTH = 4
) (
    input logic      clk,
    input logic      rst,
    ir_queue_if.slave bus
);
    // DEPTH must be a power of two >= 2 so the pointers wrap for free.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [INS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    logic is_full;
    logic is_valid;
    logic push_ok;
    logic pop_ok;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_valid = (count_q != '0);
    // A load while full still goes in when the head leaves in the same cycle.
    assign push_ok  = bus.il_in & (~is_full | bus.take_in);
    assign pop_ok   = bus.take_in & is_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (bus.flush_in) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
            if (bus.il_in & is_full & ~bus.take_in) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage is never cleared; stale words are hidden by the empty gate below.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush_in && push_ok) begin
            mem[wr_ptr] <= bus.ins_in;
        end
    end

    assign bus.ins_out   = is_valid ? mem[rd_ptr] : '0;
    assign bus.ins_valid = is_valid;
    assign bus.full      = is_full;
    assign bus.count     = count_q;
    assign bus.ovf_err   = ovf_q;
endmodule

// File: tb/tb_ir_queue.sv
// Directed and random checks of ir_queue against a queue-based reference model.
module tb_ir_queue;
    localparam int INS_W = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;

    int vectors = 0;
    int miscompares = 0;

    logic [INS_W-1:0] model_q [$];
    bit               model_ovf = 1'b0;

    ir_queue_if #(.INS_W(INS_W), .DEPTH(DEPTH)) bus ();

    ir_queue #(.INS_W(INS_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive one cycle, let the edge happen, and advance the model the same way.
    task automatic applyStimulus(input bit r, input bit il, input logic [INS_W-1:0] ins,
                                 input bit fl, input bit tk);
        int sz;
        rst          = r;
        bus.il_in    = il;
        bus.ins_in   = ins;
        bus.flush_in = fl;
        bus.take_in  = tk;
        @(posedge clk);
        sz = model_q.size();
        if (r) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (fl) begin
            model_q.delete();
        end else begin
            if (il && sz == DEPTH && !tk) model_ovf = 1'b1;
            if (tk && sz > 0) void'(model_q.pop_front());
            if (il && (sz < DEPTH || tk)) model_q.push_back(ins);
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [CNT_W-1:0] exp_count;
        logic [INS_W-1:0] exp_out;
        exp_count = CNT_W'(model_q.size());
        exp_out   = (model_q.size() != 0) ? model_q[0] : '0;

        vectors++;
        assert (bus.count === exp_count) else begin
            miscompares++;
            $error("[TB] FAIL %s count: observed %0d expected %0d", tag, bus.count, exp_count);
        end
        vectors++;
        assert (bus.ins_valid === (model_q.size() != 0)) else begin
            miscompares++;
            $error("[TB] FAIL %s ins_valid: observed %b expected %b", tag, bus.ins_valid,
                   model_q.size() != 0);
        end
        vectors++;
        assert (bus.ins_out === exp_out) else begin
            miscompares++;
            $error("[TB] FAIL %s ins_out: observed %h expected %h", tag, bus.ins_out, exp_out);
        end
        vectors++;
        assert (bus.full === (model_q.size() == DEPTH)) else begin
            miscompares++;
            $error("[TB] FAIL %s full: observed %b expected %b", tag, bus.full,
                   model_q.size() == DEPTH);
        end
        vectors++;
        assert (bus.ovf_err === model_ovf) else begin
            miscompares++;
            $error("[TB] FAIL %s ovf_err: observed %b expected %b", tag, bus.ovf_err, model_ovf);
        end
    endtask

    task automatic checkHead(input string tag, input logic [INS_W-1:0] exp_out);
        vectors++;
        assert (bus.ins_out === exp_out) else begin
            miscompares++;
            $error("[TB] FAIL %s head: observed %h expected %h", tag, bus.ins_out, exp_out);
        end
    endtask

    initial begin
        logic [INS_W-1:0] seq [4];
        seq[0] = 16'h1111; seq[1] = 16'h2222; seq[2] = 16'h3333; seq[3] = 16'h4444;

        // Reset then idle.
        applyStimulus(1, 0, '0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("reset");
        applyStimulus(0, 0, '0, 0, 0);
        checkOutput("idle");

        // Fill and drain.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, seq[i], 0, 0);
            checkOutput("fill");
        end
        for (int i = 0; i < 4; i++) begin
            checkHead("drain_order", seq[i]);
            applyStimulus(0, 0, '0, 0, 1);
            checkOutput("drain");
        end

        // Overflow while full: word dropped, head untouched, sticky flag.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, seq[i], 0, 0);
        applyStimulus(0, 1, 16'hDEAD, 0, 0);
        checkOutput("overflow");
        checkHead("overflow_head", 16'h1111);

        // Simultaneous push and pop while full, then drain across the wrap.
        applyStimulus(0, 1, 16'h5555, 0, 1);
        checkOutput("push_pop_full");
        checkHead("push_pop_head", 16'h2222);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, '0, 0, 1);
            checkOutput("wrap_drain");
        end

        // Flush with a concurrent wrong-path load.
        applyStimulus(0, 1, 16'h0A0A, 0, 0);
        applyStimulus(0, 1, 16'h0B0B, 0, 0);
        applyStimulus(0, 1, 16'hBEEF, 1, 0);
        checkOutput("flush");
        applyStimulus(0, 1, 16'hA5A5, 0, 0);
        checkOutput("post_flush_push");
        checkHead("post_flush_head", 16'hA5A5);

        // Empty take, then reset overriding load and flush.
        applyStimulus(0, 0, '0, 0, 1);
        applyStimulus(0, 0, '0, 0, 1);
        checkOutput("empty_take");
        applyStimulus(0, 1, 16'h7777, 0, 0);
        applyStimulus(1, 1, 16'h9999, 1, 0);
        checkOutput("reset_priority");

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            bit r, il, fl, tk;
            r  = ($urandom_range(99) < 2);
            il = ($urandom_range(99) < 65);
            fl = ($urandom_range(99) < 5);
            tk = ($urandom_range(99) < 45);
            applyStimulus(r, il, INS_W'($urandom), fl, tk);
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
